// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan counter.
// Segment patterns are active low: bit0 = a ... bit6 = g.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment pattern, with forced blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  bcd_t       i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_counter.sv
// 4-digit BCD tick counter driving a multiplexed common-anode display.
// Each digit slot opens with one dark cycle to suppress ghosting.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int REFRESH_COUNT = 100_000,
    parameter bit LZ_BLANK      = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_clr,
    output logic [3:0] o_an,
    output logic [6:0] o_seg,
    output logic       o_dp,
    output logic       o_wrap
);

    localparam int            RW       = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_COUNT - 1);

    bcd_t [NUM_DIGITS-1:0] d_q, d_d;
    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [3:0]            an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  wrap_q, wrap_d;

    logic                  carry;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic                  all_zero;
    logic                  lz_blank;
    logic [6:0]            dec_seg;

    // Ripple the tick through the digits in one cycle; clear has priority.
    always_comb begin
        d_d    = d_q;
        wrap_d = 1'b0;
        carry  = 1'b0;
        if (i_clr) begin
            d_d = '0;
        end else if (i_tick) begin
            carry = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (carry) begin
                    if (d_q[i] == 4'd9) begin
                        d_d[i] = 4'd0;
                    end else begin
                        d_d[i] = d_q[i] + 4'd1;
                        carry  = 1'b0;
                    end
                end
            end
            wrap_d = carry;
        end
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q + RW'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end
    end

    // upper_zero[n] is set when digit n and every digit above it are zero.
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_zero = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                all_zero = all_zero && (d_q[j] == 4'd0);
            end
            upper_zero[i] = all_zero;
        end
    end

    assign lz_blank = LZ_BLANK && (idx_q != 2'd0) && upper_zero[idx_q];

    seg7_decode u_decode (
        .i_bcd   (d_q[idx_q]),
        .i_blank (lz_blank),
        .o_seg   (dec_seg)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (ref_cnt_q != '0) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d_q       <= '0;
            ref_cnt_q <= '0;
            idx_q     <= 2'd0;
            an_q      <= AN_OFF;
            seg_q     <= SEG_BLANK;
            wrap_q    <= 1'b0;
        end else begin
            d_q       <= d_d;
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            wrap_q    <= wrap_d;
        end
    end

    assign o_an   = an_q;
    assign o_seg  = seg_q;
    assign o_dp   = 1'b1;
    assign o_wrap = wrap_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench: stimulus pushes expected display slots, cycles and wrap
// times into queues; a negedge monitor pops and compares as the DUT shows them.
module tb_seg7_scan_counter;

    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] an_n, an_l;
    logic [6:0] seg_n, seg_l;
    logic       dp_n, dp_l, wrap_n, wrap_l;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } disp_t;

    disp_t cyc_q[$];
    disp_t sq_n[$];
    disp_t sq_l[$];
    int    wrap_q[$];

    seg7_scan_counter #(.REFRESH_COUNT(RC), .LZ_BLANK(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_clr(clr),
        .o_an(an_n), .o_seg(seg_n), .o_dp(dp_n), .o_wrap(wrap_n)
    );

    seg7_scan_counter #(.REFRESH_COUNT(RC), .LZ_BLANK(1'b1)) dut_lz (
        .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_clr(clr),
        .o_an(an_l), .o_seg(seg_l), .o_dp(dp_l), .o_wrap(wrap_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    initial begin
        disp_t      e;
        int         w;
        logic [3:0] prev_n;
        logic [3:0] prev_l;
        prev_n = 4'hF;
        prev_l = 4'hF;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                checks++;
                if (an_n !== e.an || seg_n !== e.seg || dp_n !== 1'b1) begin
                    errors++;
                    $display("FAIL cycle_seq cyc=%0d: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=1",
                             cyc, an_n, seg_n, dp_n, e.an, e.seg);
                end
            end
            if (prev_n == 4'hF && an_n != 4'hF && sq_n.size() > 0) begin
                e = sq_n.pop_front();
                checks++;
                if (an_n !== e.an || seg_n !== e.seg) begin
                    errors++;
                    $display("FAIL slot_plain cyc=%0d: an=%h seg=%h, expected an=%h seg=%h",
                             cyc, an_n, seg_n, e.an, e.seg);
                end
            end
            if (prev_l == 4'hF && an_l != 4'hF && sq_l.size() > 0) begin
                e = sq_l.pop_front();
                checks++;
                if (an_l !== e.an || seg_l !== e.seg) begin
                    errors++;
                    $display("FAIL slot_lz cyc=%0d: an=%h seg=%h, expected an=%h seg=%h",
                             cyc, an_l, seg_l, e.an, e.seg);
                end
            end
            prev_n = an_n;
            prev_l = an_l;
            if (wrap_n === 1'b1) begin
                checks++;
                if (wrap_q.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_unexpected cyc=%0d: o_wrap=1, expected 0", cyc);
                end else begin
                    w = wrap_q.pop_front();
                    if (w != cyc) begin
                        errors++;
                        $display("FAIL wrap_time: seen at cyc %0d, expected cyc %0d", cyc, w);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic clr_and_tick();
        @(negedge clk);
        clr  = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        clr  = 1'b0;
        tick = 1'b0;
    endtask

    task automatic tick_expect_wrap();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        wrap_q.push_back(cyc);
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wrap_q.size() != 0) begin
            errors++;
            $display("FAIL wrap_missing: pending=%0d, expected 0", wrap_q.size());
            wrap_q.delete();
        end
    endtask

    task automatic wait_an(input logic [3:0] v, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (an_n == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Frame vectors are {seg3, seg2, seg1, seg0}.
    task automatic check_frame(input logic [27:0] en, input logic [27:0] el, input string nm);
        bit ok;
        wait_an(4'b0111, 8 * RC, ok);
        if (ok) wait_an(4'hF, RC + 2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s align: an=%h, expected 7 then F", nm, an_n);
        end else begin
            sq_n.push_back({4'hE, en[6:0]});
            sq_n.push_back({4'hD, en[13:7]});
            sq_n.push_back({4'hB, en[20:14]});
            sq_n.push_back({4'h7, en[27:21]});
            sq_l.push_back({4'hE, el[6:0]});
            sq_l.push_back({4'hD, el[13:7]});
            sq_l.push_back({4'hB, el[20:14]});
            sq_l.push_back({4'h7, el[27:21]});
            for (int i = 0; i < 6 * RC && (sq_n.size() > 0 || sq_l.size() > 0); i++)
                @(negedge clk);
            if (sq_n.size() > 0 || sq_l.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL %s drain: %0d/%0d slots not shown, expected 0", nm, sq_n.size(), sq_l.size());
                sq_n.delete();
                sq_l.delete();
            end
        end
    endtask

    task automatic push_restart_seq();
        cyc_q.push_back({4'hF, 7'h7F});
        cyc_q.push_back({4'hE, 7'h40});
        cyc_q.push_back({4'hE, 7'h40});
        cyc_q.push_back({4'hE, 7'h40});
        cyc_q.push_back({4'hF, 7'h7F});
        cyc_q.push_back({4'hD, 7'h40});
        cyc_q.push_back({4'hD, 7'h40});
        cyc_q.push_back({4'hD, 7'h40});
        cyc_q.push_back({4'hF, 7'h7F});
        cyc_q.push_back({4'hB, 7'h40});
    endtask

    initial begin
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_an",   {12'h0, an_n},  16'h000F);
        chk("rst_seg",  {9'h0, seg_n},  16'h007F);
        chk("rst_dp",   {15'h0, dp_n},  16'h0001);
        chk("rst_wrap", {14'h0, wrap_n, wrap_l}, 16'h0000);
        chk("rst_lz",   {4'h0, an_l, seg_l, dp_l}, {4'h0, 4'hF, 7'h7F, 1'b1});

        rst = 1'b0;
        @(posedge clk);
        #1;
        push_restart_seq();
        repeat (12) @(negedge clk);

        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "f0000");

        do_ticks(99);
        check_frame({7'h40, 7'h40, 7'h10, 7'h10}, {7'h7F, 7'h7F, 7'h10, 7'h10}, "f0099");
        do_ticks(1);
        check_frame({7'h40, 7'h79, 7'h40, 7'h40}, {7'h7F, 7'h79, 7'h40, 7'h40}, "f0100");

        do_clear();
        do_ticks(42);
        check_frame({7'h40, 7'h40, 7'h19, 7'h24}, {7'h7F, 7'h7F, 7'h19, 7'h24}, "f0042");
        clr_and_tick();
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "clrtick");
        do_ticks(1);
        check_frame({7'h40, 7'h40, 7'h40, 7'h79}, {7'h7F, 7'h7F, 7'h7F, 7'h79}, "f0001");
        do_ticks(6);
        check_frame({7'h40, 7'h40, 7'h40, 7'h78}, {7'h7F, 7'h7F, 7'h7F, 7'h78}, "f0007");

        do_clear();
        do_ticks(9999);
        check_frame({7'h10, 7'h10, 7'h10, 7'h10}, {7'h10, 7'h10, 7'h10, 7'h10}, "f9999");
        tick_expect_wrap();
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "wrap0000");

        do_ticks(9999);
        clr_and_tick();
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "clr9999");

        do_ticks(356);
        check_frame({7'h40, 7'h30, 7'h12, 7'h02}, {7'h7F, 7'h30, 7'h12, 7'h02}, "f0356");
        wait_an(4'b1101, 8 * RC, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL arst_align: an=%h, expected D", an_n);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_an",  {12'h0, an_n},  16'h000F);
        chk("arst_seg", {9'h0, seg_n},  16'h007F);
        chk("arst_lz",  {5'h0, an_l, seg_l}, {5'h0, 4'hF, 7'h7F});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_restart_seq();
        repeat (12) @(negedge clk);
        check_frame({7'h40, 7'h40, 7'h40, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, "arst0000");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_counter.md
# seg7_scan_counter

Downstream consumer of the 1 Hz tick from the clock divider. Holds a 4-digit BCD up-counter that advances once per tick, and time-multiplexes the four digits onto the board's common-anode seven-segment display. The drive pattern includes a dead cycle at each digit change to suppress ghosting. It is the block that drives the display pins directly.

## Interface
- `REFRESH_COUNT`, 100_000: clock cycles per digit slot (1 kHz slot, 250 Hz frame at 100 MHz); minimum 2.
- `LZ_BLANK`, 0: when 1, leading zeros in digits 3..1 are blanked; digit 0 is never blanked.
- `i_clk` in 1: system clock, 100 MHz. One clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_tick` in 1: one-cycle count-enable pulse from the divider.
- `i_clr` in 1: synchronous clear of the count.
- `o_an` out 4: anode enables, active low; bit n selects digit n, digit 0 = ones.
- `o_seg` out 7: segments, active low; bit0=a … bit6=g.
- `o_dp` out 1: decimal point, active low; held 1 (off).
- `o_wrap` out 1: one-cycle pulse when the count rolls 9999→0000.

## Operation
- **Count:** four BCD registers `d3..d0`, reset to 0.
  - Each digit is 0..9.
  - On `i_tick`, `d0` increments. A digit at 9 wraps to 0 and carries into the next digit in the same cycle.
  - 9999 + tick → 0000, and `o_wrap`=1 for exactly the following cycle.
- **Clear:**
  - `i_clr`=1 sets all digits to 0 on the next edge.
  - If `i_clr` and `i_tick` are high in the same cycle, clear wins: no increment and no `o_wrap`.
- **Scan counter `ref_cnt`:** runs 0..REFRESH_COUNT-1. At REFRESH_COUNT-1 it returns to 0 and `idx` (2 bits) advances 0→1→2→3→0.
- **Scan decode from the current state:**
  - `ref_cnt`==0 (dead cycle): anodes 4'b1111, segments 7'h7F.
  - Otherwise: `o_an` = one-hot-low of `idx`, `o_seg` = pattern of `d[idx]`.
- **Leading-zero blanking** (`LZ_BLANK`=1): digit n (n≥1) shows 7'h7F with its anode still asserted when it and all higher digits are 0.
- **Segment patterns, active low:**
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - Any code above 9 shows 7'h7F (unreachable).
- **Reset:**
  - Values: `o_an`=4'hF, `o_seg`=7'h7F, `o_dp`=1, `o_wrap`=0, `ref_cnt`=0, `idx`=0, digits 0.
  - Asserting reset mid-slot or mid-carry returns everything to these values immediately.

## Timing
- All outputs are registered and reflect the scan/count state of the previous cycle (1-cycle latency).
- After reset release:
  - Edge 1: outputs stay blank (state `ref_cnt`=0).
  - Edge 2: `o_an`=4'b1110, `o_seg`=7'h40.
- Slot length is exactly REFRESH_COUNT cycles: 1 blank cycle plus REFRESH_COUNT-1 lit cycles. Frame length is 4×REFRESH_COUNT.
- A tick at edge N updates the digits at N. The new value is visible on `o_seg` at N+1, but only if that digit's slot is lit; otherwise it appears at its next lit slot.
- `i_tick` pulses arriving on consecutive cycles each count; there is no minimum spacing.

## Structure
- Package `seg7_pkg` holds:
  - `NUM_DIGITS`=4.
  - The BCD-to-segment constants 0..9, plus `SEG_BLANK`=7'h7F and `AN_OFF`=4'hF.
  - The `bcd_t` 4-bit typedef.
- Sub-module `seg7_decode`: combinational, maps BCD + blank flag → 7-bit pattern.
- The BCD counter, scan counter and output registers stay in the top module.

## Test plan
- **Reset/first frame** (`REFRESH_COUNT`=4): release reset, no ticks.
  - `o_an` sequence per cycle: F, F, E, E, E, F, D, D, D, F, B, …
  - `o_seg`=7'h40 whenever lit.
  - `o_dp`=1 throughout.
- **Carry chain:** preload by ticking to 0099; one more tick → digits 0100.
  - Digit 2 slot shows 7'h79; digit 1 and 0 slots show 7'h40.
- **Wrap:** tick to 9999, one more tick → 0000.
  - `o_wrap` high exactly one cycle, on the edge after the tick.
- **Clear priority:** at count 0042, `i_clr`=1 with `i_tick`=1.
  - Count becomes 0000; no `o_wrap`.
  - Next tick alone → 0001.
- **Leading-zero blanking:** `LZ_BLANK`=1, count 0007.
  - Slots 3..1 show 7'h7F with anodes asserted; slot 0 shows 7'h78.
  - At count 0000, digit 0 shows 7'h40.
- **Async reset mid-slot:** assert `i_rst` between edges during a lit slot at count 0356.
  - `o_an`=4'hF and `o_seg`=7'h7F immediately, without waiting for an edge.
  - After release, count is 0000 and the scan restarts at digit 0.
